// File: rtl/multicycle_sequencer.sv
// Multicycle control sequencer: walks each instruction through FETCH/DECODE/EXEC/MEM/WB
// (or MDWAIT for mul/div), emits per-phase write strobes and counts retired instructions.
// Latency FETCH->retire: ALU/addi 4, sw 4, lw 5, NOP 3, mul/div 3+N (N MDWAIT cycles).
// No backpressure; the multdiv wait is bounded by MD_TIMEOUT and then forced to an exception.
// Ports:
//   clock, reset            rising-edge clock, async active-high reset
//   run                     fetch enable, looked at only between instructions
//   opcode, aluop           instruction fields held in IR
//   md_ready, md_exception  multdiv handshake
//   ir_we, rf_we, dmem_we, pc_we, md_mult, md_div, exc_wb   per-phase strobes
//   state, retired          debug state and retired-instruction count
module multicycle_sequencer #(
  parameter int MD_TIMEOUT = 40,
  parameter int CNT_W      = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             run,
  input  logic [4:0]       opcode,
  input  logic [4:0]       aluop,
  input  logic             md_ready,
  input  logic             md_exception,
  output logic             ir_we,
  output logic             rf_we,
  output logic             dmem_we,
  output logic             pc_we,
  output logic             md_mult,
  output logic             md_div,
  output logic             exc_wb,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] retired
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_DECODE = 3'd2;
  localparam logic [2:0] S_EXEC   = 3'd3;
  localparam logic [2:0] S_MEM    = 3'd4;
  localparam logic [2:0] S_WB     = 3'd5;
  localparam logic [2:0] S_MDWAIT = 3'd6;

  localparam int MDC_W = (MD_TIMEOUT > 2) ? $clog2(MD_TIMEOUT) : 1;
  localparam logic [MDC_W-1:0] MD_LAST = MDC_W'(MD_TIMEOUT - 1);

  logic [2:0]       state_q;
  logic [2:0]       state_d;
  logic [MDC_W-1:0] md_cnt;
  logic             exc_q;

  // Instruction classes
  logic is_r, is_mul, is_div, is_alu, is_addi, is_sw, is_lw, supported;
  assign is_r      = (opcode == 5'b00000);
  assign is_mul    = is_r && (aluop == 5'b00110);
  assign is_div    = is_r && (aluop == 5'b00111);
  assign is_alu    = is_r && !is_mul && !is_div;
  assign is_addi   = (opcode == 5'b00101);
  assign is_sw     = (opcode == 5'b00111);
  assign is_lw     = (opcode == 5'b01000);
  assign supported = is_r || is_addi || is_sw || is_lw;

  logic md_timeout;
  assign md_timeout = (md_cnt == MD_LAST);

  // State register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = S_IDLE;
    case (state_q)
      S_IDLE:   state_d = run ? S_FETCH : S_IDLE;
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        if (is_mul || is_div)                        state_d = S_MDWAIT;
        else if (is_alu || is_addi || is_sw || is_lw) state_d = S_EXEC;
        else                                         state_d = S_WB;
      end
      S_EXEC:   state_d = (is_sw || is_lw) ? S_MEM : S_WB;
      // sw retires straight out of MEM; lw needs WB for the synchronous read data
      S_MEM:    state_d = is_sw ? (run ? S_FETCH : S_IDLE) : S_WB;
      S_MDWAIT: state_d = (md_ready || md_timeout) ? S_WB : S_MDWAIT;
      S_WB:     state_d = run ? S_FETCH : S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Output decode, purely from registered state so reset forces everything low
  always_comb begin
    ir_we   = 1'b0;
    rf_we   = 1'b0;
    dmem_we = 1'b0;
    pc_we   = 1'b0;
    md_mult = 1'b0;
    md_div  = 1'b0;
    exc_wb  = 1'b0;
    case (state_q)
      S_FETCH:  ir_we = 1'b1;
      S_DECODE: begin
        md_mult = is_mul;
        md_div  = is_div;
      end
      S_MEM: begin
        dmem_we = is_sw;
        pc_we   = is_sw;
      end
      S_WB: begin
        pc_we  = 1'b1;
        rf_we  = supported;
        exc_wb = exc_q;
      end
      default: ;
    endcase
  end

  // Multdiv wait counter, exception flag, retired counter
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      md_cnt  <= '0;
      exc_q   <= 1'b0;
      retired <= '0;
    end else begin
      if (state_q == S_DECODE)      md_cnt <= '0;
      else if (state_q == S_MDWAIT) md_cnt <= md_cnt + 1'b1;

      // A result arriving in the timeout cycle takes priority over the timeout
      if (state_q == S_MDWAIT) begin
        if (md_ready)        exc_q <= md_exception;
        else if (md_timeout) exc_q <= 1'b1;
      end else if (state_q == S_WB) begin
        exc_q <= 1'b0;
      end

      if (pc_we) retired <= retired + 1'b1;
    end
  end

  assign state = state_q;

endmodule
